// File: rtl/chatter_pkg.sv
// Shared definitions for the contact-bounce generator: FSM encoding,
// LFSR taps/seed and the LFSR step function.
package chatter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/chatter_lfsr.sv
// 16-bit Fibonacci LFSR that only moves when stepped, so the gap sequence
// is reproducible from reset.
module chatter_lfsr
    import chatter_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;

    // LFSR state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/chatter_gen.sv
// Contact-bounce generator: turns a clean button level into a bouncing one
// with 2*PAIRS+1 toggles separated by pseudo-random gaps.
module chatter_gen
    import chatter_pkg::*;
#(
    parameter int                 PAIRS    = 3,
    parameter int                 MIN_GAP  = 2,
    parameter int                 GAP_W    = 8,
    parameter logic [GAP_W-1:0]   GAP_MASK = 8'h1F,
    parameter logic [15:0]        SEED     = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_in,
    output logic btn_out,
    output logic busy
);

    localparam int TOG_TOTAL = 2 * PAIRS + 1;
    localparam int TOG_W     = $clog2(TOG_TOTAL + 1);

    state_e             state_q;
    logic               btn_out_q;
    logic               busy_q;
    logic               target_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [TOG_W-1:0]   tog_cnt_q;

    logic [15:0]        lfsr_val;
    logic               lfsr_step;
    logic [GAP_W-1:0]   gap_init;

    chatter_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .step_i  (lfsr_step),
        .value_o (lfsr_val)
    );

    assign gap_init = GAP_W'(MIN_GAP) + (lfsr_val[GAP_W-1:0] & GAP_MASK);

    generate
        if (GAP_W < 16) begin : g_lfsr_sink
            logic lfsr_unused;
            assign lfsr_unused = ^lfsr_val[15:GAP_W];
        end
    endgenerate

    // The LFSR steps exactly when the FSM loads a new gap
    always_comb begin
        lfsr_step = 1'b0;
        if (en && (state_q == ST_IDLE) && (btn_in != target_q)) begin
            lfsr_step = 1'b1;
        end else if (en && (state_q == ST_GAP) && (gap_cnt_q <= GAP_W'(1))
                     && (tog_cnt_q != TOG_W'(1))) begin
            lfsr_step = 1'b1;
        end else begin
            lfsr_step = 1'b0;
        end
    end

    // FSM, gap/toggle counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            btn_out_q <= 1'b1;
            busy_q    <= 1'b0;
            target_q  <= 1'b1;
            gap_cnt_q <= '0;
            tog_cnt_q <= '0;
        end else if (!en) begin
            state_q   <= ST_IDLE;
            btn_out_q <= btn_in;
            target_q  <= btn_in;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_in != target_q) begin
                        target_q  <= btn_in;
                        gap_cnt_q <= gap_init;
                        tog_cnt_q <= TOG_W'(TOG_TOTAL);
                        busy_q    <= 1'b1;
                        state_q   <= ST_GAP;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q > GAP_W'(1)) begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end else begin
                        btn_out_q <= ~btn_out_q;
                        tog_cnt_q <= tog_cnt_q - TOG_W'(1);
                        if (tog_cnt_q == TOG_W'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            gap_cnt_q <= gap_init;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign btn_out = btn_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_chatter_gen.sv
// Directed bench for chatter_gen: default instance plus a minimal
// single-toggle instance (PAIRS=0, MIN_GAP=1, GAP_MASK=0).
module tb_chatter_gen;

    logic clk;
    logic rst;
    logic en, btn_in, btn_out, busy;
    logic en2, btn2, btn_out2, busy2;

    int n_checks = 0;
    int n_fails  = 0;

    chatter_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .btn_in  (btn_in),
        .btn_out (btn_out),
        .busy    (busy)
    );

    chatter_gen #(
        .PAIRS    (0),
        .MIN_GAP  (1),
        .GAP_W    (8),
        .GAP_MASK (8'h00)
    ) dut_min (
        .clk     (clk),
        .rst     (rst),
        .en      (en2),
        .btn_in  (btn2),
        .btn_out (btn_out2),
        .busy    (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        int tog_at[7];
        int k;
        int toggles;
        logic exp_o;
        logic prev;
        bit done;

        tog_at = '{3, 8, 17, 34, 66, 96, 123};

        // Reset with btn_in low, then pass-through
        rst = 1'b1; en = 1'b0; btn_in = 1'b0; en2 = 1'b0; btn2 = 1'b1;
        repeat (3) tick();
        check("reset_btn_out", btn_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("pass_lo", btn_out, 1'b0);
        btn_in = 1'b1;
        tick();
        check("pass_hi", btn_out, 1'b1);

        // Bounce 1->0 with gaps 3,5,9,17,32,30,27; btn_in back high at cycle 20
        en = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);
        btn_in = 1'b0;
        tick();
        check("accept_busy", busy, 1'b1);
        check("accept_out", btn_out, 1'b1);
        exp_o = 1'b1;
        k = 0;
        for (int c = 1; c <= 123; c++) begin
            if (c == 20) btn_in = 1'b1;
            tick();
            if (k < 7 && c == tog_at[k]) begin
                exp_o = ~exp_o;
                k++;
            end
            check($sformatf("seq1_out_c%0d", c), btn_out, exp_o);
            check($sformatf("seq1_busy_c%0d", c), busy, (c < 123) ? 1'b1 : 1'b0);
        end

        // Pending btn_in=1 starts a new sequence one cycle after busy falls
        tick();
        check("seq2_start_busy", busy, 1'b1);
        check("seq2_start_out", btn_out, 1'b0);
        toggles = 0;
        done = 1'b0;
        prev = btn_out;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (btn_out !== prev) toggles++;
            prev = btn_out;
            if (busy === 1'b0) done = 1'b1;
        end
        check("seq2_finished", done, 1'b1);
        check("seq2_final_out", btn_out, 1'b1);
        check("seq2_toggle_cnt", (toggles == 7), 1'b1);

        // Reset mid-sequence, then repeat 1->0 and abort during the 3rd gap
        btn_in = 1'b0;
        tick();
        check("seq3_busy", busy, 1'b1);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("midrst_out", btn_out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("seq4_accept_busy", busy, 1'b1);
        exp_o = 1'b1;
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 12) en = 1'b0;
            tick();
            if (c == 12) begin
                check("abort_out", btn_out, 1'b0);
                check("abort_busy", busy, 1'b0);
            end else begin
                if (k < 7 && c == tog_at[k]) begin
                    exp_o = ~exp_o;
                    k++;
                end
                check($sformatf("seq4_out_c%0d", c), btn_out, exp_o);
                check($sformatf("seq4_busy_c%0d", c), busy, 1'b1);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            check($sformatf("post_abort_out_c%0d", c), btn_out, 1'b0);
            check($sformatf("post_abort_busy_c%0d", c), busy, 1'b0);
        end

        // Minimal instance: one toggle one cycle after acceptance
        en2 = 1'b1;
        tick();
        check("min_idle_busy", busy2, 1'b0);
        check("min_idle_out", btn_out2, 1'b1);
        btn2 = 1'b0;
        tick();
        check("min_accept_busy", busy2, 1'b1);
        check("min_accept_out", btn_out2, 1'b1);
        tick();
        check("min_toggle_busy", busy2, 1'b0);
        check("min_toggle_out", btn_out2, 1'b0);
        tick();
        check("min_hold_busy", busy2, 1'b0);
        check("min_hold_out", btn_out2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
